// File: rtl/wb_stage_sel_if.sv
// MEM->WB stage bus plus decode-stage forwarding taps, grouped for wb_stage_sel.
// Latency: n/a (signal bundle only).
// Backpressure: en/flush carry stall and bubble requests into the stage.
interface wb_stage_sel_if #(
   parameter int DATA_W = 32,
   parameter int NSRC   = 3,
   parameter int SEL_W  = 2,
   parameter int REG_AW = 5
);
   // pipeline control
   logic                   en;
   logic                   flush;
   // MEM-stage candidates
   logic                   m_valid;
   logic                   m_regwrite;
   logic [REG_AW-1:0]      m_rt;
   logic [REG_AW-1:0]      m_rd;
   logic [1:0]             m_a3sel;
   logic [SEL_W-1:0]       m_wdsel;
   logic [NSRC*DATA_W-1:0] m_src;
   logic [DATA_W-1:0]      m_pc;
   // decode-stage read taps
   logic [REG_AW-1:0]      d_rs;
   logic [REG_AW-1:0]      d_rt;
   logic [DATA_W-1:0]      d_rs_grf;
   logic [DATA_W-1:0]      d_rt_grf;
   // W-stage state toward the GRF
   logic                   w_valid;
   logic                   w_we;
   logic [REG_AW-1:0]      w_a3;
   logic [DATA_W-1:0]      w_wd;
   logic [DATA_W-1:0]      w_pc;
   // forwarded operands
   logic [DATA_W-1:0]      d_rs_fwd;
   logic [DATA_W-1:0]      d_rt_fwd;

   // pipeline side: drives MEM candidates and decode reads, sees W state
   modport master (
      output en, flush, m_valid, m_regwrite, m_rt, m_rd, m_a3sel, m_wdsel, m_src, m_pc,
      output d_rs, d_rt, d_rs_grf, d_rt_grf,
      input  w_valid, w_we, w_a3, w_wd, w_pc, d_rs_fwd, d_rt_fwd
   );

   // write-back stage side
   modport slave (
      input  en, flush, m_valid, m_regwrite, m_rt, m_rd, m_a3sel, m_wdsel, m_src, m_pc,
      input  d_rs, d_rt, d_rs_grf, d_rt_grf,
      output w_valid, w_we, w_a3, w_wd, w_pc, d_rs_fwd, d_rt_fwd
   );
endinterface

// File: rtl/wb_stage_sel.sv
// MEM/WB register with A3/WD selection, gated GRF write enable and W->D forwarding.
// Latency: 1 cycle MEM->W; forwarding is combinational off the W registers.
// Backpressure: en=0 holds every register; flush loads a bubble and beats en.
// Optional: RETIRE_CNT_EN adds the 32-bit retire_cnt port and counter.
module wb_stage_sel #(
   parameter int DATA_W   = 32,
   parameter int NSRC     = 3,
   parameter int SEL_W    = 2,
   parameter int REG_AW   = 5,
   parameter int LINK_REG = 31
) (
   input  logic             clk,
   input  logic             reset_n,
   wb_stage_sel_if.slave    bus
`ifdef RETIRE_CNT_EN
   ,
   output logic [31:0]      retire_cnt
`endif
);

   logic              valid_q, valid_d;
   logic              we_q,    we_d;
   logic [REG_AW-1:0] a3_q,    a3_d;
   logic [DATA_W-1:0] wd_q,    wd_d;
   logic [DATA_W-1:0] pc_q,    pc_d;

   logic [REG_AW-1:0] a3_res;
   logic [DATA_W-1:0] wd_res;
   logic              capture;

   // capture happens only on an advancing, non-flushed edge
   assign capture = bus.en & ~bus.flush;

   // resolve destination register and write data from the MEM candidates
   always_comb begin
      a3_res = '0;
      wd_res = '0;
      unique case (bus.m_a3sel)
         2'd0:    a3_res = bus.m_rt;
         2'd1:    a3_res = bus.m_rd;
         2'd2:    a3_res = REG_AW'(LINK_REG);
         default: a3_res = '0;
      endcase
      // indices past the last real source fall through to the zero default
      for (int k = 0; k < NSRC; k++) begin
         if (bus.m_wdsel == SEL_W'(k)) begin
            wd_res = bus.m_src[k*DATA_W +: DATA_W];
         end
      end
   end

   // next-state: flush loads a bubble, capture loads MEM, otherwise hold
   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      a3_d    = a3_q;
      wd_d    = wd_q;
      pc_d    = pc_q;
      if (bus.flush) begin
         valid_d = 1'b0;
         we_d    = 1'b0;
         a3_d    = '0;
         wd_d    = '0;
         pc_d    = '0;
      end else if (bus.en) begin
         valid_d = bus.m_valid;
         we_d    = bus.m_regwrite & bus.m_valid & (a3_res != '0);
         a3_d    = a3_res;
         wd_d    = wd_res;
         pc_d    = bus.m_pc;
      end
   end

   // W-stage registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         a3_q    <= '0;
         wd_q    <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         a3_q    <= a3_d;
         wd_q    <= wd_d;
         pc_q    <= pc_d;
      end
   end

   assign bus.w_valid = valid_q;
   assign bus.w_we    = we_q;
   assign bus.w_a3    = a3_q;
   assign bus.w_wd    = wd_q;
   assign bus.w_pc    = pc_q;

   // W->D bypass; we_q is already zero for $0, the explicit check keeps $0 safe regardless
   assign bus.d_rs_fwd = (we_q && (bus.d_rs != '0) && (bus.d_rs == a3_q)) ? wd_q : bus.d_rs_grf;
   assign bus.d_rt_fwd = (we_q && (bus.d_rt != '0) && (bus.d_rt == a3_q)) ? wd_q : bus.d_rt_grf;

`ifdef RETIRE_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // count valid instructions entering W; wraps naturally at 2^32
   always_comb begin
      cnt_d = cnt_q;
      if (capture && bus.m_valid) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // retired-instruction counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign retire_cnt = cnt_q;
`else
   logic unused_capture;
   assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_wb_stage_sel.sv
// Directed bench for wb_stage_sel: reset, capture, $0 gating, stall/flush, forwarding.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: exercises en=0 holds and flush-over-en bubbles.
module tb_wb_stage_sel;
   localparam int DATA_W = 32;
   localparam int NSRC   = 3;
   localparam int SEL_W  = 2;
   localparam int REG_AW = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   wb_stage_sel_if #(.DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .REG_AW(REG_AW)) bus ();

`ifdef RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   wb_stage_sel #(
      .DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .REG_AW(REG_AW), .LINK_REG(31)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
`ifdef RETIRE_CNT_EN
      ,
      .retire_cnt(retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // advance one edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input logic v, input logic rw, input logic [1:0] a3sel,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] wdsel,
                        input logic [31:0] dm, input logic [31:0] alu, input logic [31:0] pc8,
                        input logic [31:0] pc);
      bus.m_valid    = v;
      bus.m_regwrite = rw;
      bus.m_a3sel    = a3sel;
      bus.m_rt       = rt;
      bus.m_rd       = rd;
      bus.m_wdsel    = wdsel;
      bus.m_src      = {pc8, alu, dm};
      bus.m_pc       = pc;
   endtask

   initial begin
      bus.en = 1'b0; bus.flush = 1'b0;
      set_m(1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      bus.d_rs = '0; bus.d_rt = '0; bus.d_rs_grf = '0; bus.d_rt_grf = '0;

      // reset state
      #12;
      chk("rst_valid", 64'(bus.w_valid), 64'd0);
      chk("rst_wd", 64'(bus.w_wd), 64'd0);
      reset_n = 1'b1;
      #1;

      // jal: link register gets PC+8
      bus.en = 1'b1;
      set_m(1'b1, 1'b1, 2'd2, 5'd4, 5'd6, 2'd2, 32'h2222, 32'h1111, 32'h0000_3008, 32'h0000_3000);
      step();
      chk("jal_a3", 64'(bus.w_a3), 64'd31);
      chk("jal_wd", 64'(bus.w_wd), 64'h3008);
      chk("jal_we", 64'(bus.w_we), 64'd1);
      chk("jal_valid", 64'(bus.w_valid), 64'd1);
      chk("jal_pc", 64'(bus.w_pc), 64'h3000);
      bus.d_rs = 5'd31; bus.d_rs_grf = 32'hAAAA; bus.d_rt = 5'd5; bus.d_rt_grf = 32'hBBBB;
      #1;
      chk("jal_fwd_rs", 64'(bus.d_rs_fwd), 64'h3008);
      chk("jal_fwd_rt", 64'(bus.d_rt_fwd), 64'hBBBB);

      // async reset mid-cycle with w_wd=0x1234
      set_m(1'b1, 1'b1, 2'd0, 5'd9, 5'd0, 2'd1, 32'h0, 32'h1234, 32'h0, 32'h0000_3004);
      step();
      chk("pre_rst_wd", 64'(bus.w_wd), 64'h1234);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_wd", 64'(bus.w_wd), 64'd0);
      chk("arst_we", 64'(bus.w_we), 64'd0);
      chk("arst_a3", 64'(bus.w_a3), 64'd0);
      chk("arst_pc", 64'(bus.w_pc), 64'd0);
      chk("arst_valid", 64'(bus.w_valid), 64'd0);
      #2 reset_n = 1'b1;

      // write to $0 is suppressed and never forwarded
      set_m(1'b1, 1'b1, 2'd1, 5'd3, 5'd0, 2'd1, 32'h0, 32'hDEAD, 32'h0, 32'h0000_3010);
      step();
      chk("z_we", 64'(bus.w_we), 64'd0);
      chk("z_wd", 64'(bus.w_wd), 64'hDEAD);
      bus.d_rs = 5'd0; bus.d_rs_grf = 32'd0;
      #1;
      chk("z_fwd_rs", 64'(bus.d_rs_fwd), 64'd0);

      // invalid instruction with regwrite does not write
      set_m(1'b0, 1'b1, 2'd0, 5'd7, 5'd0, 2'd1, 32'h0, 32'h77, 32'h0, 32'h0);
      step();
      chk("inv_we", 64'(bus.w_we), 64'd0);
      chk("inv_valid", 64'(bus.w_valid), 64'd0);

      // lw $8 <- 0x55, then stall three cycles with different MEM inputs
      set_m(1'b1, 1'b1, 2'd0, 5'd8, 5'd0, 2'd0, 32'h55, 32'h66, 32'h0, 32'h0000_3020);
      step();
      chk("lw_we", 64'(bus.w_we), 64'd1);
      bus.en = 1'b0;
      set_m(1'b1, 1'b1, 2'd0, 5'd3, 5'd0, 2'd0, 32'h77, 32'h0, 32'h0, 32'h0000_3024);
      bus.d_rt = 5'd8; bus.d_rt_grf = 32'h99;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_a3", 64'(bus.w_a3), 64'd8);
         chk("stall_wd", 64'(bus.w_wd), 64'h55);
         chk("stall_fwd_rt", 64'(bus.d_rt_fwd), 64'h55);
      end
      chk("stall_pc", 64'(bus.w_pc), 64'h3020);

      // flush beats en
      bus.en = 1'b1; bus.flush = 1'b1;
      step();
      chk("fl_valid", 64'(bus.w_valid), 64'd0);
      chk("fl_we", 64'(bus.w_we), 64'd0);
      chk("fl_wd", 64'(bus.w_wd), 64'd0);
      chk("fl_fwd_rt", 64'(bus.d_rt_fwd), 64'h99);
      bus.flush = 1'b0;

      // out-of-range write-data select yields 0
      set_m(1'b1, 1'b1, 2'd1, 5'd0, 5'd12, 2'd3, 32'h11, 32'h22, 32'h33, 32'h0000_3030);
      step();
      chk("oor_wd", 64'(bus.w_wd), 64'd0);
      chk("oor_a3", 64'(bus.w_a3), 64'd12);

      // select 3 on A3 forces register 0
      set_m(1'b1, 1'b1, 2'd3, 5'd4, 5'd5, 2'd1, 32'h11, 32'h22, 32'h33, 32'h0000_3034);
      step();
      chk("a3z_a3", 64'(bus.w_a3), 64'd0);
      chk("a3z_we", 64'(bus.w_we), 64'd0);

`ifdef RETIRE_CNT_EN
      // 5 valid captures interleaved with 2 stalls and a flush
      reset_n = 1'b0;
      #1;
      chk("cnt_rst", 64'(retire_cnt), 64'd0);
      reset_n = 1'b1;
      set_m(1'b1, 1'b1, 2'd0, 5'd2, 5'd0, 2'd1, 32'h0, 32'h1, 32'h0, 32'h0);
      bus.en = 1'b1; step(); step();
      bus.en = 1'b0; step(); step();
      bus.en = 1'b1; bus.flush = 1'b1; step();
      bus.flush = 1'b0; step(); step(); step();
      chk("cnt_five", 64'(retire_cnt), 64'd5);
      bus.m_valid = 1'b0; step();
      chk("cnt_bubble", 64'(retire_cnt), 64'd5);
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      bus.m_valid = 1'b1; step();
      chk("cnt_wrap", 64'(retire_cnt), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #20000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "timeout");
   end
endmodule
